sr_dmem_ctrl: RTL and testbench

- Data-memory controller placed directly downstream of the single-cycle CPU's data-memory port.
- Converts a CPU access into a handshaked word-bus transaction: byte/half/word ops, lane shifting, byte enables and load sign/zero extension.
- Asserts a combinational stall so the CPU holds PC and request until the access completes.
- Detects misaligned accesses and suppresses them.

---
 rtl/sr_dmem_ctrl_pkg.sv | 33 +++
 rtl/sr_dmem_lane.sv | 49 ++++
 rtl/sr_dmem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sr_dmem_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_dmem_ctrl_pkg.sv
// rtl/sr_dmem_ctrl_pkg.sv - shared types and constants for the data-memory controller
package sr_dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SR_DMEM_IDLE = 2'd0,
    SR_DMEM_REQ  = 2'd1,
    SR_DMEM_WAIT = 2'd2,
    SR_DMEM_DONE = 2'd3
  } stateT;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } sizeT;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // An access is rejected when the size is not exactly one-hot or the
  // address does not sit on its natural boundary.
  function automatic logic isMisaligned(input logic opByte, input logic opHalf,
                                        input logic opWord, input logic [1:0] lane);
    logic oneHot;
    oneHot = (opByte & ~opHalf & ~opWord) | (~opByte & opHalf & ~opWord) |
             (~opByte & ~opHalf & opWord);
    return ~oneHot | (opHalf & lane[0]) | (opWord & (lane != 2'b00));
  endfunction

endpackage

// File: rtl/sr_dmem_lane.sv
// rtl/sr_dmem_lane.sv - write lane replication/byte enables and read lane extract/extend
module sr_dmem_lane
  import sr_dmem_ctrl_pkg::*;
(
  input  sizeT        wrSize,
  input  logic [1:0]  wrLane,
  input  logic [31:0] wrData,
  output logic [31:0] wrWord,
  output logic [3:0]  wrBe,
  input  sizeT        rdSize,
  input  logic [1:0]  rdLane,
  input  logic        rdSign,
  input  logic [31:0] rdWord,
  output logic [31:0] rdExt
);

  logic [7:0]  rdByte;
  logic [15:0] rdHalf;

  // Replicate the right-aligned store data into every lane; enables pick the target lane.
  always_comb begin
    wrWord = wrData;
    wrBe   = BE_WORD;
    case (wrSize)
      SZ_BYTE: begin
        wrWord = {4{wrData[7:0]}};
        wrBe   = BE_BYTE << wrLane;
      end
      SZ_HALF: begin
        wrWord = {2{wrData[15:0]}};
        wrBe   = BE_HALF << {wrLane[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Pull the addressed lane out of the bus word and sign/zero-extend it.
  always_comb begin
    rdByte = rdWord[{rdLane, 3'b000} +: 8];
    rdHalf = rdWord[{rdLane[1], 4'b0000} +: 16];
    rdExt  = rdWord;
    case (rdSize)
      SZ_BYTE: rdExt = {{24{rdSign & rdByte[7]}}, rdByte};
      SZ_HALF: rdExt = {{16{rdSign & rdHalf[15]}}, rdHalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/sr_dmem_ctrl.sv
// rtl/sr_dmem_ctrl.sv - CPU data-memory port to handshaked word bus (optional SR_DMEM_TIMEOUT_EN)
module sr_dmem_ctrl
  import sr_dmem_ctrl_pkg::*;
#(
  parameter int          AW      = 30,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          op_byte,
  input  logic          op_half,
  input  logic          op_word,
  input  logic          cpu_sign,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_misalign,
  output logic          cpu_fault,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [31:0]   bus_rdata
);

  stateT       state, stateNext;
  sizeT        wrSize, reqSize;
  logic        reqSign;
  logic [1:0]  reqLane;
  logic [31:0] rdataQ, wrWord, rdExt;
  logic [3:0]  wrBe;
  logic        misaligned, accept, timeoutHit;

  assign misaligned   = isMisaligned(op_byte, op_half, op_word, cpu_addr[1:0]);
  assign cpu_misalign = cpu_req & misaligned;
  assign accept       = cpu_req & ~misaligned;
  assign wrSize       = op_word ? SZ_WORD : (op_half ? SZ_HALF : SZ_BYTE);
  // A rejected access must never hand the CPU stale load data.
  assign cpu_rdata    = cpu_misalign ? '0 : rdataQ;

  sr_dmem_lane uLane (
    .wrSize (wrSize),
    .wrLane (cpu_addr[1:0]),
    .wrData (cpu_wdata),
    .wrWord (wrWord),
    .wrBe   (wrBe),
    .rdSize (reqSize),
    .rdLane (reqLane),
    .rdSign (reqSign),
    .rdWord (bus_rdata),
    .rdExt  (rdExt)
  );

`ifdef SR_DMEM_TIMEOUT_EN
  localparam int CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] toCnt;
  logic            faultQ;

  // A real handshake in the final cycle still wins over the abort.
  assign timeoutHit = (((state == SR_DMEM_REQ) && !bus_gnt) ||
                       ((state == SR_DMEM_WAIT) && !bus_rvalid)) &&
                      (toCnt == CntW'(TIMEOUT - 1));
  assign cpu_fault  = faultQ;

  // Cycle counter for the outstanding access; fault pulses for the aborted DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt  <= '0;
      faultQ <= 1'b0;
    end else begin
      faultQ <= timeoutHit;
      if (state == SR_DMEM_REQ || state == SR_DMEM_WAIT) toCnt <= toCnt + 1'b1;
      else toCnt <= '0;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign cpu_fault  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SR_DMEM_IDLE;
    else     state <= stateNext;
  end

  // Next-state and CPU stall.
  always_comb begin
    stateNext = state;
    cpu_stall = 1'b0;
    case (state)
      SR_DMEM_IDLE: begin
        cpu_stall = accept;
        if (accept) stateNext = SR_DMEM_REQ;
      end
      SR_DMEM_REQ: begin
        cpu_stall = 1'b1;
        if (bus_gnt)         stateNext = bus_we ? SR_DMEM_DONE : SR_DMEM_WAIT;
        else if (timeoutHit) stateNext = SR_DMEM_DONE;
      end
      SR_DMEM_WAIT: begin
        cpu_stall = 1'b1;
        if (bus_rvalid || timeoutHit) stateNext = SR_DMEM_DONE;
      end
      SR_DMEM_DONE: stateNext = SR_DMEM_IDLE;
      default:      stateNext = SR_DMEM_IDLE;
    endcase
  end

  // Request latch, bus drive and load-result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      reqSize   <= SZ_BYTE;
      reqSign   <= 1'b0;
      reqLane   <= 2'b00;
      rdataQ    <= '0;
    end else begin
      case (state)
        SR_DMEM_IDLE: begin
          if (accept) begin
            bus_req   <= 1'b1;
            bus_we    <= cpu_we;
            bus_addr  <= cpu_addr[AW+1:2];
            bus_be    <= wrBe;
            bus_wdata <= wrWord;
            reqSize   <= wrSize;
            reqSign   <= cpu_sign;
            reqLane   <= cpu_addr[1:0];
          end
        end
        SR_DMEM_REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
          end else if (timeoutHit) begin
            bus_req <= 1'b0;
            rdataQ  <= '0;
          end
        end
        SR_DMEM_WAIT: begin
          if (bus_rvalid)      rdataQ <= rdExt;
          else if (timeoutHit) rdataQ <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_dmem_ctrl.sv
// tb/tb_sr_dmem_ctrl.sv - self-checking bench for sr_dmem_ctrl
module tb_sr_dmem_ctrl;

`ifdef SR_DMEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, op_byte, op_half, op_word, cpu_sign;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_misalign, cpu_fault;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  op;      // 0 byte, 1 half, 2 word, 3 none
    logic        sign;
    logic [31:0] rdWord;
    logic [3:0]  be;
    logic [31:0] wWord;
    logic [31:0] rWord;
    logic        mis;
    int          gntDly;
    int          rvDly;
  } vecT;

  vecT vecs[14];

  sr_dmem_ctrl #(.AW(30), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .op_byte(op_byte), .op_half(op_half), .op_word(op_word), .cpu_sign(cpu_sign),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign),
    .cpu_fault(cpu_fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runVec(input vecT v);
    int cyc, reqCyc, doneCyc, gntCyc, expDone;
    logic [31:0] expR;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    op_byte = (v.op == 2'd0); op_half = (v.op == 2'd1); op_word = (v.op == 2'd2);
    cpu_sign = v.sign;
    #1;
    chk("misalign", {31'b0, cpu_misalign}, {31'b0, v.mis});
    if (v.mis) begin
      chk("mis_stall", {31'b0, cpu_stall}, 32'd0);
      chk("mis_rdata", cpu_rdata, 32'd0);
      step();
      chk("mis_bus_req", {31'b0, bus_req}, 32'd0);
      cpu_req = 1'b0;
      return;
    end
    chk("idle_stall", {31'b0, cpu_stall}, 32'd1);
    if (!v.we) sb.push_back(v.rWord);
    cyc = 0; reqCyc = 0; doneCyc = -1; gntCyc = -1;
    while (doneCyc < 0 && cyc < 60) begin
      step();
      cyc++;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      if (bus_req) begin
        reqCyc++;
        chk("req_stall", {31'b0, cpu_stall}, 32'd1);
        chk("bus_addr", {2'b0, bus_addr}, {2'b0, v.addr[31:2]});
        chk("bus_be", {28'b0, bus_be}, {28'b0, v.be});
        chk("bus_we", {31'b0, bus_we}, {31'b0, v.we});
        if (v.we) chk("bus_wdata", bus_wdata, v.wWord);
        // stray read data during REQ must be ignored
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        if (reqCyc == v.gntDly + 1) begin
          bus_gnt = 1'b1;
          gntCyc = cyc;
        end
      end else if (cpu_stall) begin
        if (cyc == gntCyc + v.rvDly) begin
          bus_rvalid = 1'b1;
          bus_rdata = v.rdWord;
        end
      end else begin
        doneCyc = cyc;
      end
    end
    if (doneCyc < 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      cpu_req = 1'b0;
      return;
    end
    expDone = v.we ? v.gntDly + 2 : v.gntDly + 2 + v.rvDly;
    chk("done_cycle", doneCyc, expDone);
    chk("req_cycles", reqCyc, v.gntDly + 1);
    chk("done_fault", {31'b0, cpu_fault}, 32'd0);
    expR = cpu_rdata;
    if (!v.we) begin
      if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else begin
        expR = sb.pop_front();
        chk("cpu_rdata", cpu_rdata, expR);
      end
    end
    cpu_req = 1'b0;
    step();
    chk("after_stall", {31'b0, cpu_stall}, 32'd0);
    chk("after_bus_req", {31'b0, bus_req}, 32'd0);
    if (!v.we) chk("rdata_hold", cpu_rdata, expR);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we    addr         wdata         op    sgn  rdWord        be      wWord         rWord         mis  g  rv
    vecs[0]  = '{1'b1, 32'h103, 32'h0000_00A5, 2'd0, 1'b0, 32'h0,         4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b0, 0, 0};
    vecs[1]  = '{1'b0, 32'h102, 32'h0,         2'd1, 1'b1, 32'h8001_1234, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0, 0, 2};
    vecs[2]  = '{1'b0, 32'h102, 32'h0,         2'd1, 1'b0, 32'h8001_1234, 4'b1100, 32'h0,         32'h0000_8001, 1'b0, 1, 1};
    vecs[3]  = '{1'b1, 32'h200, 32'h1234_BEEF, 2'd1, 1'b0, 32'h0,         4'b0011, 32'hBEEF_BEEF, 32'h0,         1'b0, 2, 0};
    vecs[4]  = '{1'b1, 32'h204, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0, 5, 0};
    vecs[5]  = '{1'b0, 32'h302, 32'h0,         2'd0, 1'b1, 32'h11F0_2233, 4'b0100, 32'h0,         32'hFFFF_FFF0, 1'b0, 0, 1};
    vecs[6]  = '{1'b0, 32'h303, 32'h0,         2'd0, 1'b0, 32'h8000_0000, 4'b1000, 32'h0,         32'h0000_0080, 1'b0, 3, 3};
    vecs[7]  = '{1'b0, 32'h010, 32'h0,         2'd2, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0, 0, 1};
    vecs[8]  = '{1'b0, 32'h006, 32'h0,         2'd2, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0, 0};
    vecs[9]  = '{1'b1, 32'h101, 32'h0000_5555, 2'd1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0, 0};
    vecs[10] = '{1'b0, 32'h000, 32'h0,         2'd3, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0, 0};
    vecs[11] = '{1'b0, 32'h100, 32'h0,         2'd1, 1'b1, 32'h0000_7FFF, 4'b0011, 32'h0,         32'h0000_7FFF, 1'b0, 1, 2};
    vecs[12] = '{1'b0, 32'h001, 32'h0,         2'd0, 1'b1, 32'h0000_8000, 4'b0010, 32'h0,         32'hFFFF_FF80, 1'b0, 0, 1};
    vecs[13] = '{1'b1, 32'h000, 32'h0000_01FF, 2'd0, 1'b0, 32'h0,         4'b0001, 32'hFFFF_FFFF, 32'h0,         1'b0, 0, 0};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    op_byte = 1'b0; op_half = 1'b0; op_word = 1'b0; cpu_sign = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    step();
    step();
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_bus_addr", {2'b0, bus_addr}, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_fault", {31'b0, cpu_fault}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) runVec(vecs[i]);

    // reset while waiting for read data
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    op_byte = 1'b0; op_half = 1'b0; op_word = 1'b1; cpu_sign = 1'b0;
    step();
    chk("rw_req", {31'b0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("rw_wait_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rw_wait_req", {31'b0, bus_req}, 32'd0);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rw_rst_req", {31'b0, bus_req}, 32'd0);
    chk("rw_rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rw_rst_rdata", cpu_rdata, 32'd0);
    chk("rw_rst_be", {28'b0, bus_be}, 32'd0);
    step();
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    step();
    bus_rvalid = 1'b0;
    chk("rw_late_rdata", cpu_rdata, 32'd0);
    chk("rw_late_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rw_late_req", {31'b0, bus_req}, 32'd0);

`ifdef SR_DMEM_TIMEOUT_EN
    begin
      int reqCyc, cyc;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      op_byte = 1'b0; op_half = 1'b0; op_word = 1'b1; cpu_sign = 1'b0;
      reqCyc = 0; cyc = 0;
      step();
      while (cpu_stall && cyc < 30) begin
        if (bus_req) reqCyc++;
        cyc++;
        step();
      end
      chk("to_req_cycles", reqCyc, 32'd4);
      chk("to_fault", {31'b0, cpu_fault}, 32'd1);
      chk("to_rdata", cpu_rdata, 32'd0);
      chk("to_bus_req", {31'b0, bus_req}, 32'd0);
      cpu_req = 1'b0;
      step();
      chk("to_fault_pulse", {31'b0, cpu_fault}, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
